// File: rtl/alu_req_pkg.sv
// Shared constants for the two-requester arithmetic arbiter.
// Opcodes, requester indices, result-width derivation and FSM states.
package alu_req_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int RES_W_DEF  = 2 * DATA_W_DEF + 1;

  localparam logic [1:0] OP_ADDMUL = 2'd0;
  localparam logic [1:0] OP_SUBXOR = 2'd1;
  localparam logic [1:0] OP_ANDOR  = 2'd2;
  localparam logic [1:0] OP_MODMAC = 2'd3;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic int res_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } res_state_t;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational arithmetic unit: one of four opcodes on a, b, c.
// Operands are widened to the result width before any arithmetic.
module alu_exec_core
  import alu_req_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = res_w(DATA_W)
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [1:0]        op,
  output logic [RES_W-1:0]  result,
  output logic              err
);

  logic [RES_W-1:0]  ea;
  logic [RES_W-1:0]  eb;
  logic [RES_W-1:0]  ec;
  logic [RES_W-1:0]  emod;
  logic [DATA_W-1:0] m;
  logic              bz;

  always_comb begin
    ea   = RES_W'(a);
    eb   = RES_W'(b);
    ec   = RES_W'(c);
    bz   = (b == '0);
    // a mod 0 is defined as 0; the error flag reports it
    m    = bz ? '0 : (a % b);
    emod = RES_W'(m);
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADDMUL: result = (ea + eb) * ec;
      OP_SUBXOR: result = (ea - eb) ^ ec;
      OP_ANDOR:  result = ea & (eb | ec);
      OP_MODMAC: begin
        result = emod + ea * ec;
        err    = bz;
      end
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester front end for the shared arithmetic unit.
// Arbitrates, registers one result with tag/error, counts grants.
module alu_req_arbiter
  import alu_req_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_W     = res_w(DATA_W),
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req0_c,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [DATA_W-1:0] req1_c,
  input  logic [1:0]        req1_op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_src,
  output logic              res_err,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  res_state_t state, state_d;

  logic              last_q;
  logic              prio;
  logic              grant0;
  logic              grant1;
  logic              can_accept;
  logic              hs0;
  logic              hs1;
  logic              accept;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [1:0]        op;
  logic [RES_W-1:0]  result;
  logic              err;

  assign prio = (PRIO_MODE != 0);

  // last_q holds the most recent winner; the other side wins a tie
  assign grant0 = req0_valid & (~req1_valid | prio | last_q);
  assign grant1 = req1_valid & ~grant0;

  assign can_accept = (state == EMPTY) | res_ready;
  assign req0_ready = grant0 & can_accept & ~rst;
  assign req1_ready = grant1 & can_accept & ~rst;
  assign hs0    = req0_valid & req0_ready;
  assign hs1    = req1_valid & req1_ready;
  assign accept = hs0 | hs1;

  assign a  = grant1 ? req1_a  : req0_a;
  assign b  = grant1 ? req1_b  : req0_b;
  assign c  = grant1 ? req1_c  : req0_c;
  assign op = grant1 ? req1_op : req0_op;

  alu_exec_core #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_core (
    .a      (a),
    .b      (b),
    .c      (c),
    .op     (op),
    .result (result),
    .err    (err)
  );

  assign res_valid = (state == FULL);

  always_comb begin
    state_d = state;
    unique case (state)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (res_ready && !accept) state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      last_q     <= REQ1;
      res_data   <= '0;
      res_src    <= REQ0;
      res_err    <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        last_q   <= grant1;
        res_data <= result;
        res_src  <= grant1;
        res_err  <= err;
      end
      if (hs0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (hs1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: vector table, corner sequences,
// and random traffic against an opcode-level reference model.
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req0_c = '0;
  logic [1:0] req0_op = '0;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_a = '0, req1_b = '0, req1_c = '0;
  logic [1:0] req1_op = '0;
  logic       res_ready = 1'b1;

  logic        rr_req0_ready, rr_req1_ready, rr_res_valid;
  logic [8:0]  rr_res_data;
  logic        rr_res_src, rr_res_err;
  logic [15:0] rr_cnt0, rr_cnt1;

  logic        fp_req0_ready, fp_req1_ready, fp_res_valid;
  logic [8:0]  fp_res_data;
  logic        fp_res_src, fp_res_err;
  logic [3:0]  fp_cnt0, fp_cnt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.DATA_W(4), .PRIO_MODE(0), .CNT_W(16)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_op(req1_op),
    .res_valid(rr_res_valid), .res_ready(res_ready),
    .res_data(rr_res_data), .res_src(rr_res_src), .res_err(rr_res_err),
    .grant_cnt0(rr_cnt0), .grant_cnt1(rr_cnt1)
  );

  alu_req_arbiter #(.DATA_W(4), .PRIO_MODE(1), .CNT_W(4)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_op(req1_op),
    .res_valid(fp_res_valid), .res_ready(res_ready),
    .res_data(fp_res_data), .res_src(fp_res_src), .res_err(fp_res_err),
    .grant_cnt0(fp_cnt0), .grant_cnt1(fp_cnt1)
  );

  typedef struct {
    logic       src;
    logic [1:0] op;
    int         a, b, c;
    int         exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: plain integer arithmetic, reduced mod 2^9
  function automatic logic [9:0] model(input logic [1:0] op,
                                       input int a, b, c);
    int r;
    logic e;
    e = 1'b0;
    case (op)
      2'd0: r = (a + b) * c;
      2'd1: r = (a - b) ^ c;
      2'd2: r = a & (b | c);
      default: begin
        r = ((b == 0) ? 0 : a % b) + a * c;
        e = (b == 0);
      end
    endcase
    return {e, 9'(r & 511)};
  endfunction

  task automatic set_req(input logic src, input logic [1:0] op,
                         input int a, b, c);
    if (src) begin
      req1_valid = 1'b1; req1_op = op;
      req1_a = 4'(a); req1_b = 4'(b); req1_c = 4'(c);
    end else begin
      req0_valid = 1'b1; req0_op = op;
      req0_a = 4'(a); req0_b = 4'(b); req0_c = 4'(c);
    end
  endtask

  int         ec0, ec1;
  logic       pv[2];
  logic [1:0] pop[2];
  logic [3:0] pa[2], pb[2], pc[2];
  logic       m_valid, m_src, m_err, m_last, win, e0, e1, can;
  logic [8:0] m_data;
  logic [9:0] mr;

  initial begin
    vt[0] = '{1'b0, 2'd0, 3, 4, 5, 35, 1'b0};
    vt[1] = '{1'b1, 2'd1, 2, 5, 1, 508, 1'b0};
    vt[2] = '{1'b1, 2'd2, 12, 10, 5, 12, 1'b0};
    vt[3] = '{1'b0, 2'd3, 7, 0, 3, 21, 1'b1};
    vt[4] = '{1'b0, 2'd3, 15, 4, 15, 228, 1'b0};

    tick(); tick();
    check("rst_valid", rr_res_valid, 0);
    check("rst_data", rr_res_data, 0);
    check("rst_src", rr_res_src, 0);
    check("rst_err", rr_res_err, 0);
    check("rst_cnt0", rr_cnt0, 0);
    check("rst_cnt1", rr_cnt1, 0);
    rst = 1'b0;
    tick();

    ec0 = 0; ec1 = 0;
    for (int i = 0; i < 5; i++) begin
      set_req(vt[i].src, vt[i].op, vt[i].a, vt[i].b, vt[i].c);
      #1;
      check("vec_ready", vt[i].src ? rr_req1_ready : rr_req0_ready, 1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (vt[i].src) ec1++; else ec0++;
      check("vec_valid", rr_res_valid, 1);
      check("vec_data", rr_res_data, vt[i].exp_data);
      check("vec_src", rr_res_src, vt[i].src);
      check("vec_err", rr_res_err, vt[i].exp_err);
      check("vec_cnt0", rr_cnt0, ec0);
      check("vec_cnt1", rr_cnt1, ec1);
    end
    tick();
    check("drain_valid", rr_res_valid, 0);

    // consumer stall holds the result and both readies low
    set_req(1'b0, 2'd0, 1, 1, 1);
    tick();
    ec0++;
    check("hold_load", rr_res_data, 2);
    res_ready = 1'b0;
    set_req(1'b1, 2'd2, 12, 10, 5);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_rdy0", rr_req0_ready, 0);
      check("hold_rdy1", rr_req1_ready, 0);
      check("hold_valid", rr_res_valid, 1);
      check("hold_data", rr_res_data, 2);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("rel_rdy1", rr_req1_ready, 1);
    check("rel_rdy0", rr_req0_ready, 0);
    tick();
    ec1++;
    check("b2b_valid", rr_res_valid, 1);
    check("b2b_data", rr_res_data, 12);
    check("b2b_src", rr_res_src, 1);
    check("b2b_cnt1", rr_cnt1, ec1);

    // async reset while FULL with both requesters valid
    set_req(1'b0, 2'd0, 3, 4, 5);
    rst = 1'b1;
    #1;
    check("arst_valid", rr_res_valid, 0);
    check("arst_cnt0", rr_cnt0, 0);
    check("arst_cnt1", rr_cnt1, 0);
    check("arst_rdy0", rr_req0_ready, 0);
    check("arst_rdy1", rr_req1_ready, 0);
    check("arst_fp_valid", fp_res_valid, 0);
    tick();
    check("rst_edge_valid", rr_res_valid, 0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("rr_rdy0", rr_req0_ready, (k % 2) == 0);
      check("fp_rdy1", fp_req1_ready, 0);
      tick();
      check("rr_src", rr_res_src, k % 2);
      check("rr_data", rr_res_data, (k % 2) ? 12 : 35);
      check("rr_valid", rr_res_valid, 1);
      check("fp_src", fp_res_src, 0);
      #1;
    end
    check("rr_cnt0", rr_cnt0, 3);
    check("rr_cnt1", rr_cnt1, 3);
    check("fp_cnt0", fp_cnt0, 6);
    check("fp_cnt1", fp_cnt1, 0);

    // counters saturate rather than wrap
    req1_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check("sat_reach", fp_cnt0, 4'hF);
    for (int k = 0; k < 6; k++) tick();
    check("sat_hold", fp_cnt0, 4'hF);
    check("sat_rr_cnt0", rr_cnt0, 18);
    req0_valid = 1'b0;

    // random traffic against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_valid = 0; m_data = '0; m_src = 0; m_err = 0; m_last = 1;
    ec0 = 0; ec1 = 0;
    pv[0] = 0; pv[1] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r]) begin
          pv[r]  = ($urandom_range(0, 99) < 60);
          pop[r] = 2'($urandom_range(0, 3));
          pa[r]  = 4'($urandom_range(0, 15));
          pb[r]  = 4'($urandom_range(0, 15));
          pc[r]  = 4'($urandom_range(0, 15));
        end
      end
      req0_valid = pv[0]; req0_op = pop[0];
      req0_a = pa[0]; req0_b = pb[0]; req0_c = pc[0];
      req1_valid = pv[1]; req1_op = pop[1];
      req1_a = pa[1]; req1_b = pb[1]; req1_c = pc[1];
      res_ready = ($urandom_range(0, 99) < 70);
      #1;
      can = !m_valid || res_ready;
      if (pv[0] && pv[1]) win = !m_last;
      else win = pv[1];
      e0 = pv[0] && !win && can;
      e1 = pv[1] && win && can;
      check("rnd_rdy0", rr_req0_ready, e0);
      check("rnd_rdy1", rr_req1_ready, e1);
      tick();
      if (e0 || e1) begin
        mr = model(pop[win], int'(pa[win]), int'(pb[win]),
                   int'(pc[win]));
        m_data = mr[8:0]; m_err = mr[9];
        m_src = win; m_last = win; m_valid = 1;
        pv[win] = 0;
        if (win) ec1++; else ec0++;
      end else if (res_ready) begin
        m_valid = 0;
      end
      check("rnd_valid", rr_res_valid, m_valid);
      if (m_valid) begin
        check("rnd_data", rr_res_data, m_data);
        check("rnd_src", rr_res_src, m_src);
        check("rnd_err", rr_res_err, m_err);
      end
      check("rnd_cnt0", rr_cnt0, ec0);
      check("rnd_cnt1", rr_cnt1, ec1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one 4-operand-width arithmetic unit between two requesters over valid/ready handshakes.
- Uses round-robin or fixed-priority arbitration and registers the result with a source tag and an error flag.
- Sits between the instruction/command sources and the result consumer; it is the only path into the shared arithmetic unit.
- Throughput is one operation per cycle when the consumer does not stall.

Parameters:
- DATA_W, 4, operand width of a, b, c.
- RES_W, 2*DATA_W+1, result width (9 at default).
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with req0 highest.
- CNT_W, 16, width of the per-requester grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b, req0_c  in  DATA_W each  requester 0 operands.
- req0_op  in  2  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_c, req1_op  same as requester 0, for requester 1.
- res_valid  out  1  result register holds an unconsumed result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  RES_W  registered result.
- res_src  out  1  index of the requester that produced res_data.
- res_err  out  1  op 3 was executed with b == 0.
- grant_cnt0, grant_cnt1  out  CNT_W each  saturating count of accepted operations per requester.

Behaviour:
- Reset (asynchronous, on rst high) clears: res_valid=0, res_data=0, res_src=0, res_err=0, grant_cnt0/1=0. The round-robin pointer is set so that req0 wins the first contention.
- Reset asserted mid-operation discards any held result. No handshake completes in a reset cycle.
- Opcodes, computed modulo 2^RES_W:
  - 0: (a+b)*c
  - 1: (a-b) XOR c, with a-b as RES_W-bit two's complement
  - 2: a AND (b OR c), zero-extended
  - 3: (a mod b) + a*c
- Op 3 with b==0: the mod term is defined as 0, and res_err=1 for that result. For all other results res_err=0.
- No intermediate truncation below RES_W.
- can_accept = !res_valid | res_ready.
- Grant (combinational):
  - Only one valid requester: it wins.
  - Both valid, PRIO_MODE=0: the requester not granted most recently wins.
  - Both valid, PRIO_MODE=1: req0 wins.
- reqN_ready = grantN & can_accept. A handshake is reqN_valid & reqN_ready.
- Ready never asserts for a requester whose valid is low.
- The round-robin pointer updates only on a completed handshake.
- Latency: an operation accepted in cycle T appears on res_data/res_src/res_err with res_valid=1 in cycle T+1.
- FSM, two states:
  - EMPTY: res_valid=0. Goes to FULL on accept.
  - FULL: res_valid=1.
    - res_ready=1 with a new accept in the same cycle: stays FULL and loads the new result (back-to-back).
    - res_ready=1 with no accept: goes to EMPTY.
    - res_ready=0: holds res_data/res_src/res_err stable and deasserts both reqN_ready.
- grant_cntN increments on each reqN handshake and saturates at all-ones (no wrap).
- A requester's inputs must stay stable while valid and not ready. The block samples only on the handshake.

Decomposition:
- Package alu_req_pkg: opcode localparams OP_ADDMUL=2'd0, OP_SUBXOR=2'd1, OP_ANDOR=2'd2, OP_MODMAC=2'd3; RES_W derivation; requester index constants.
- One sub-module, alu_exec_core: purely combinational. Takes a, b, c, op; returns result and div0 err, implementing the opcode table including the b==0 rule.
- Arbitration, FSM, result register and counters stay in alu_req_arbiter.

Test Plan:
1. req0 op0 a=3 b=4 c=5, res_ready=1 -> next cycle res_valid=1, res_data=35, res_src=0, res_err=0, grant_cnt0=1.
2. req1 op1 a=2 b=5 c=1 -> res_data=0x1FC (508); req1 op2 a=12 b=10 c=5 -> res_data=12.
3. req0 op3 a=7 b=0 c=3 -> res_data=21, res_err=1; then op3 a=15 b=4 c=15 -> res_data=228, res_err=0.
4. Both requesters valid continuously, PRIO_MODE=0, res_ready=1 -> grants alternate 0,1,0,1 with one result per cycle. With PRIO_MODE=1 -> req1 never granted while req0 stays valid.
5. res_ready=0 for 3 cycles with a result held -> res_data stable, req0_ready=req1_ready=0. Release -> back-to-back result loads in the same cycle the old one drains.
6. Assert rst while FULL with both requesters valid -> res_valid=0 immediately, counters=0. After release, req0 is granted first. Force grant_cnt0 near all-ones -> it saturates at 0xFFFF.
